// File: rtl/graph_pkg.sv
// Shared encodings for the graph edge server: FSM states, config selects, node-entry layout.
package graph_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OUT_START,
        ST_OUT_END,
        ST_GAP,
        ST_STREAM,
        ST_HALT
    } state_e;

    localparam logic [1:0] CFG_SEL_NODE = 2'd0;
    localparam logic [1:0] CFG_SEL_EDGE = 2'd1;
    localparam logic [1:0] CFG_SEL_PAIR = 2'd2;

    // Node entry is {deg, base}: base at bit 0, deg directly above the edge-address field.
    localparam int NODE_BASE_LSB = 0;
    localparam int PAIR_START_LSB = 0;
    localparam int PAIR_END_LSB   = 16;

    // Wider than any node index; sliced down to the configured width.
    localparam logic [31:0] NULL_NODE_IDX = '1;

    function automatic int node_deg_lsb(input int eaw);
        return NODE_BASE_LSB + eaw;
    endfunction

endpackage

// File: rtl/graph_adj_mem.sv
// Adjacency storage: node degree/base table, packed edge list and two start/end pairs.
// Flop arrays with combinational reads and a single registered write port; all cleared on reset.
module graph_adj_mem
    import graph_pkg::*;
#(
    parameter int NW  = 10,
    parameter int CW  = 4,
    parameter int NE  = 2048,
    parameter int EAW = $clog2(NE)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [1:0]     wr_sel,
    input  logic [15:0]    wr_addr,
    input  logic [31:0]    wr_data,
    input  logic [NW-1:0]  node_addr,
    output logic [CW-1:0]  node_deg,
    output logic [EAW-1:0] node_base,
    input  logic [EAW-1:0] edge_addr,
    output logic [NW-1:0]  edge_idx,
    input  logic           pair_sel,
    output logic [NW-1:0]  pair_start,
    output logic [NW-1:0]  pair_end
);

    localparam int DEG_LSB = node_deg_lsb(EAW);

    logic [EAW+CW-1:0] node_q  [2**NW];
    logic [NW-1:0]     edge_q  [NE];
    logic [NW-1:0]     start_q [2];
    logic [NW-1:0]     end_q   [2];

    logic unused_wr;
    assign unused_wr = ^{wr_addr, wr_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**NW; i++) node_q[i] <= '0;
            for (int i = 0; i < NE; i++)    edge_q[i] <= '0;
            for (int i = 0; i < 2; i++) begin
                start_q[i] <= '0;
                end_q[i]   <= '0;
            end
        end else if (wr_en) begin
            case (wr_sel)
                CFG_SEL_NODE: node_q[wr_addr[NW-1:0]]  <= wr_data[EAW+CW-1:0];
                CFG_SEL_EDGE: edge_q[wr_addr[EAW-1:0]] <= wr_data[NW-1:0];
                CFG_SEL_PAIR: begin
                    start_q[wr_addr[0]] <= wr_data[PAIR_START_LSB +: NW];
                    end_q[wr_addr[0]]   <= wr_data[PAIR_END_LSB +: NW];
                end
                default: ;
            endcase
        end
    end

    assign node_deg   = node_q[node_addr][DEG_LSB +: CW];
    assign node_base  = node_q[node_addr][NODE_BASE_LSB +: EAW];
    assign edge_idx   = edge_q[edge_addr];
    assign pair_start = start_q[pair_sel];
    assign pair_end   = end_q[pair_sel];

endmodule

// File: rtl/graph_edge_server.sv
// Node-fetch responder: emits start/end indices, then streams each requested node's out-edges.
// Registered outputs, one edge per cycle; start_run low freezes everything, done_reg parks in HALT.
module graph_edge_server
    import graph_pkg::*;
#(
    parameter int PARAM_NODE_IDX_WIDTH = 10,
    parameter int PARAM_COUNTER_WIDTH  = 4,
    parameter int PARAM_NUM_EDGES      = 2048
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_run,
    input  logic                            part_sel,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0] node_idx_reg,
    input  logic                            rd_next_node_reg,
    input  logic                            done_reg,
    output logic [PARAM_NODE_IDX_WIDTH-1:0] next_node_idx,
    output logic [PARAM_COUNTER_WIDTH-1:0]  next_node_counter,
    input  logic                            cfg_we,
    input  logic [1:0]                      cfg_sel,
    input  logic [15:0]                     cfg_addr,
    input  logic [31:0]                     cfg_wdata
);

    localparam int NW  = PARAM_NODE_IDX_WIDTH;
    localparam int CW  = PARAM_COUNTER_WIDTH;
    localparam int EAW = $clog2(PARAM_NUM_EDGES);
    localparam logic [CW-1:0]  CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [EAW-1:0] PTR_ONE = {{(EAW-1){1'b0}}, 1'b1};

    state_e         state_q, state_d;
    logic [NW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [EAW-1:0] ptr_q, ptr_d;
    logic           psel_q, psel_d;

    logic           mem_wr_en;
    logic           pair_rd_sel;
    logic [CW-1:0]  node_deg;
    logic [EAW-1:0] node_base;
    logic [EAW-1:0] edge_addr;
    logic [NW-1:0]  edge_idx;
    logic [NW-1:0]  pair_start;
    logic [NW-1:0]  pair_end;

    assign mem_wr_en   = cfg_we && !start_run && (state_q == ST_IDLE);
    assign pair_rd_sel = (state_q == ST_IDLE) ? part_sel : psel_q;
    assign edge_addr   = (state_q == ST_GAP) ? node_base : ptr_q;

    graph_adj_mem #(
        .NW (NW),
        .CW (CW),
        .NE (PARAM_NUM_EDGES),
        .EAW(EAW)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (mem_wr_en),
        .wr_sel    (cfg_sel),
        .wr_addr   (cfg_addr),
        .wr_data   (cfg_wdata),
        .node_addr (node_idx_reg),
        .node_deg  (node_deg),
        .node_base (node_base),
        .edge_addr (edge_addr),
        .edge_idx  (edge_idx),
        .pair_sel  (pair_rd_sel),
        .pair_start(pair_start),
        .pair_end  (pair_end)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        psel_d  = psel_q;
        if (start_run) begin
            if (done_reg) begin
                state_d = ST_HALT;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        psel_d  = part_sel;
                        idx_d   = pair_start;
                        cnt_d   = '0;
                        state_d = ST_OUT_START;
                    end
                    ST_OUT_START: begin
                        idx_d   = pair_end;
                        state_d = ST_OUT_END;
                    end
                    ST_OUT_END: state_d = ST_GAP;
                    ST_GAP: begin
                        if (rd_next_node_reg) begin
                            if (node_deg != '0) begin
                                idx_d = edge_idx;
                                cnt_d = node_deg;
                                ptr_d = node_base + PTR_ONE;
                            end else begin
                                // Leaf node: a single NULL beat so the engine still sees a last edge.
                                idx_d = NULL_NODE_IDX[NW-1:0];
                                cnt_d = CNT_ONE;
                            end
                            state_d = ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        if (cnt_q > CNT_ONE) begin
                            idx_d = edge_idx;
                            cnt_d = cnt_q - CNT_ONE;
                            ptr_d = ptr_q + PTR_ONE;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end
                    ST_HALT: ;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            psel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            psel_q  <= psel_d;
        end
    end

    assign next_node_idx     = idx_q;
    assign next_node_counter = cnt_q;

endmodule

// File: tb/tb_graph_edge_server.sv
// Directed bench for graph_edge_server: hand-computed start/end/edge sequences, freeze, HALT and reset.
module tb_graph_edge_server;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_run = 1'b0;
    logic        part_sel = 1'b0;
    logic [9:0]  node_idx_reg = '0;
    logic        rd_next_node_reg = 1'b0;
    logic        done_reg = 1'b0;
    logic [9:0]  next_node_idx;
    logic [3:0]  next_node_counter;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_sel = '0;
    logic [15:0] cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    graph_edge_server dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_run        (start_run),
        .part_sel         (part_sel),
        .node_idx_reg     (node_idx_reg),
        .rd_next_node_reg (rd_next_node_reg),
        .done_reg         (done_reg),
        .next_node_idx    (next_node_idx),
        .next_node_counter(next_node_counter),
        .cfg_we           (cfg_we),
        .cfg_sel          (cfg_sel),
        .cfg_addr         (cfg_addr),
        .cfg_wdata        (cfg_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int idx, input int cnt);
        check({tag, ".idx"}, int'(next_node_idx), idx);
        check({tag, ".cnt"}, int'(next_node_counter), cnt);
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [15:0] addr, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = addr;
        cfg_wdata = data;
        step();
        cfg_we    = 1'b0;
    endtask

    initial begin
        #3;
        expect_out("reset", 0, 0);
        #9 rst_n = 1'b1;
        step();

        // Run A: pair0 {end 9, start 5}; node5 {3,0}; node3 {3,2046}; edges 0..2 = 7,8,9; 2046,2047 = 11,12
        cfg_write(2'd2, 16'd0, (32'd9 << 16) | 32'd5);
        cfg_write(2'd0, 16'd5, (32'd3 << 11) | 32'd0);
        cfg_write(2'd0, 16'd3, (32'd3 << 11) | 32'd2046);
        cfg_write(2'd1, 16'd0, 32'd7);
        cfg_write(2'd1, 16'd1, 32'd8);
        cfg_write(2'd1, 16'd2, 32'd9);
        cfg_write(2'd1, 16'd2046, 32'd11);
        cfg_write(2'd1, 16'd2047, 32'd12);
        expect_out("idle", 0, 0);

        start_run = 1'b1; part_sel = 1'b0; node_idx_reg = 10'd5; rd_next_node_reg = 1'b1;
        step(); expect_out("start0", 5, 0);
        step(); expect_out("end0", 9, 0);
        step(); expect_out("gap0", 9, 0);
        step(); expect_out("n5e0", 7, 3);
        step(); expect_out("n5e1", 8, 2);
        step(); expect_out("n5e2", 9, 1);
        node_idx_reg = 10'd7;
        step(); expect_out("gap1", 9, 1);
        step(); expect_out("leaf", 1023, 1);
        node_idx_reg = 10'd3;
        step(); expect_out("gap2", 1023, 1);
        step(); expect_out("wrap0", 11, 3);
        step(); expect_out("wrap1", 12, 2);
        step(); expect_out("wrap2", 7, 1);
        node_idx_reg = 10'd5;
        step(); expect_out("gap3", 7, 1);

        // Config writes while running must be dropped
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = 16'd5; cfg_wdata = (32'd1 << 11);
        step(); expect_out("cfgrun0", 7, 3);
        cfg_we = 1'b0;
        step(); expect_out("cfgrun1", 8, 2);

        start_run = 1'b0; cfg_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); expect_out("frozen", 8, 2);
        end
        cfg_we = 1'b0; start_run = 1'b1;
        step(); expect_out("resume", 9, 1);
        step(); expect_out("gap4", 9, 1);
        step(); expect_out("unchanged", 7, 3);

        done_reg = 1'b1;
        step(); expect_out("halt0", 7, 3);
        done_reg = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(); expect_out("halt", 7, 3);
        end

        rst_n = 1'b0;
        #2;
        expect_out("rst_a", 0, 0);
        start_run = 1'b0; rd_next_node_reg = 1'b0;
        #2 rst_n = 1'b1;
        step();

        // Run B: pair1 {end 4, start 2}; node2 {2,4}; edges 4,5 = 6,3; node5 must read back cleared
        cfg_write(2'd2, 16'd1, (32'd4 << 16) | 32'd2);
        cfg_write(2'd0, 16'd2, (32'd2 << 11) | 32'd4);
        cfg_write(2'd1, 16'd4, 32'd6);
        cfg_write(2'd1, 16'd5, 32'd3);

        start_run = 1'b1; part_sel = 1'b1; node_idx_reg = 10'd5; rd_next_node_reg = 1'b0;
        step(); expect_out("start1", 2, 0);
        step(); expect_out("end1", 4, 0);
        step(); expect_out("gapB0", 4, 0);
        step(); expect_out("no_rd", 4, 0);
        rd_next_node_reg = 1'b1;
        step(); expect_out("cleared", 1023, 1);
        node_idx_reg = 10'd2;
        step(); expect_out("gapB1", 1023, 1);
        step(); expect_out("n2e0", 6, 2);
        #3 rst_n = 1'b0;
        #1 expect_out("rst_mid", 0, 0);
        step(); expect_out("rst_hold", 0, 0);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
